// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input, W-bit valid/ready stream multiplexer with a
// registered output stage.
//   MODE = 0 : channel picked by the sel port (sel >= N picks nothing)
//   MODE = 1 : round-robin arbitration starting after the last granted channel
// Optional feature macro: MUX_PKT_LOCK_EN
//   When defined, a beat with in_last = 0 locks the mux onto its channel
//   until that channel delivers a beat with in_last = 1.
module stream_mux_n #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    grant
);

    logic          w_load;
    logic          w_chosen;
    logic          w_xfer;
    logic [SW-1:0] w_chan;
    logic [SW-1:0] w_rr_idx;
    logic [W-1:0]  w_data;
    logic          w_last;

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic          r_last;
    logic [SW-1:0] r_grant;
    logic [SW-1:0] r_ptr;
`ifdef MUX_PKT_LOCK_EN
    logic          r_lock;
    logic [SW-1:0] r_lock_ch;
`endif

    // Output register can accept a new beat when empty or being drained now.
    assign w_load = !r_valid || out_ready;

    // Channel choice: external select or round-robin search, overridden by a held packet lock.
    always_comb begin
        w_chan   = '0;
        w_chosen = 1'b0;
        w_rr_idx = '0;
        if (MODE == 0) begin
            if (int'(sel) < N) begin
                w_chan   = sel;
                w_chosen = 1'b1;
            end
        end else begin
            // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
            for (int k = N; k >= 1; k--) begin
                w_rr_idx = SW'((int'(r_ptr) + k) % N);
                if (in_valid[w_rr_idx]) begin
                    w_chan   = w_rr_idx;
                    w_chosen = 1'b1;
                end
            end
        end
`ifdef MUX_PKT_LOCK_EN
        if (r_lock) begin
            w_chan   = r_lock_ch;
            w_chosen = 1'b1;
        end
`endif
    end

    // Data and last of the chosen channel.
    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_chan == SW'(k)) begin
                w_data = in_data[k*W +: W];
                w_last = in_last[k];
            end
        end
    end

    // Only the chosen channel sees ready; in_valid does not gate it.
    always_comb begin
        in_ready = '0;
        if (w_load && w_chosen) begin
            in_ready[w_chan] = 1'b1;
        end
    end

    assign w_xfer = w_load && w_chosen && in_valid[w_chan];

    // Output register, round-robin pointer and packet lock; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= SW'(N - 1);
`ifdef MUX_PKT_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
`endif
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data  <= w_data;
                r_last  <= w_last;
                r_grant <= w_chan;
                if (MODE == 1) begin
                    r_ptr <= w_chan;
                end
`ifdef MUX_PKT_LOCK_EN
                r_lock    <= !w_last;
                r_lock_ch <= w_chan;
`endif
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign grant     = r_grant;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one MODE=0 and one MODE=1 instance share all
// inputs; a behavioural model of the handshake rules predicts ready,
// output beat and grant each cycle. Honours MUX_PKT_LOCK_EN if defined.
module tb_stream_mux_n;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_valid;
    logic [1:0]     sel;
    logic           out_ready;

    logic [N-1:0]   rdy0, rdy1;
    logic [W-1:0]   od0, od1;
    logic           ol0, ol1, ov0, ov1;
    logic [1:0]     g0, g1;

    always #5 clk = ~clk;

    stream_mux_n #(.N(N), .W(W), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(rdy0), .sel(sel), .out_data(od0),
        .out_last(ol0), .out_valid(ov0), .out_ready(out_ready), .grant(g0)
    );

    stream_mux_n #(.N(N), .W(W), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(rdy1), .sel(sel), .out_data(od1),
        .out_last(ol1), .out_valid(ov1), .out_ready(out_ready), .grant(g1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state, index 0 = MODE 0 instance, 1 = MODE 1 instance.
    bit       m_valid [2];
    bit [7:0] m_data  [2];
    bit       m_last  [2];
    int       m_grant [2];
    int       m_ptr   [2];
    bit       m_lock  [2];
    int       m_lockch[2];

`ifdef MUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    function automatic int pick(int m);
        if (m_lock[m]) return m_lockch[m];
        if (m == 0) return (int'(sel) < N) ? int'(sel) : -1;
        for (int d = 1; d <= N; d++)
            if (in_valid[(m_ptr[m] + d) % N]) return (m_ptr[m] + d) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_last[m] = 0; m_grant[m] = 0;
            m_ptr[m] = N - 1; m_lock[m] = 0; m_lockch[m] = 0;
        end
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic cyc();
        int           c[2];
        bit           load[2];
        logic [N-1:0] exp_rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            c[m]    = pick(m);
            load[m] = !m_valid[m] || out_ready;
            exp_rdy = '0;
            if (load[m] && c[m] >= 0) exp_rdy[c[m]] = 1'b1;
            check(m == 0 ? "in_ready0" : "in_ready1", m == 0 ? rdy0 : rdy1, exp_rdy);
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            for (int m = 0; m < 2; m++) begin
                if (load[m]) begin
                    m_valid[m] = (c[m] >= 0) && in_valid[c[m]];
                    if (m_valid[m]) begin
                        m_data[m]  = in_data[c[m]*W +: W];
                        m_last[m]  = in_last[c[m]];
                        m_grant[m] = c[m];
                        if (m == 1) m_ptr[m] = c[m];
                        if (LOCK_EN) begin
                            m_lock[m]   = !in_last[c[m]];
                            m_lockch[m] = c[m];
                        end
                    end
                end
            end
        end
        #1;
        check("out_valid0", ov0, m_valid[0]);
        check("out_data0",  od0, m_data[0]);
        check("out_last0",  ol0, m_last[0]);
        check("grant0",     g0,  m_grant[0]);
        check("out_valid1", ov1, m_valid[1]);
        check("out_data1",  od1, m_data[1]);
        check("out_last1",  ol1, m_last[1]);
        check("grant1",     g1,  m_grant[1]);
        @(negedge clk);
    endtask

    int exp3[6]  = '{0, 1, 2, 3, 0, 1};
    int exp4[4]  = '{0, 3, 0, 3};
    int exp5[4];
    bit seq5[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1; in_data = '0; in_last = '1; in_valid = '0; sel = 0; out_ready = 1;
        @(posedge clk); #1; model_reset();
        @(negedge clk);
        check("rst_valid0", ov0, 0);
        check("rst_data0",  od0, 0);
        check("rst_grant1", g1, 0);
        cyc();
        rst = 0;

        // select channel 2
        sel = 2; in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5;
        #1 check("t1_rdy", rdy0, 4'b0100);
        cyc();
        check("t1_valid", ov0, 1);
        check("t1_data", od0, 8'hA5);
        check("t1_grant", g0, 2);

        // stall with changing sel and data
        out_ready = 0;
        repeat (3) begin
            sel = 2'($urandom); in_data = N*W'($urandom);
            cyc();
            check("t2_rdy", rdy0, 0);
            check("t2_hold_data", od0, 8'hA5);
            check("t2_hold_grant", g0, 2);
        end
        out_ready = 1; sel = 1; in_valid = 4'b0010; in_data[1*W +: W] = 8'h3C;
        cyc();
        check("t2_next_data", od0, 8'h3C);
        check("t2_next_grant", g0, 1);

        // round robin, all requesting
        rst = 1; cyc(); rst = 0;
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t3_rr", g1, exp3[i]);
        end

        // two requesters, then a single one
        rst = 1; cyc(); rst = 0;
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_alt", g1, exp4[i]);
        end
        in_valid = 4'b0010;
        repeat (3) begin
            cyc();
            check("t4_single", g1, 1);
        end

        // packet lock on channel 1
        if (LOCK_EN) exp5 = '{1, 1, 1, 2};
        else         exp5 = '{1, 2, 0, 1};
        rst = 1; cyc(); rst = 0;
        in_valid = 4'b0001; cyc();
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_last = 4'b1111; in_last[1] = seq5[i];
            cyc();
            check("t5_lock", g1, exp5[i]);
        end
        in_last = '1;

        // reset mid-packet
        in_valid = 4'b0010; in_last = 4'b0000; cyc();
        out_ready = 0; rst = 1; cyc();
        check("t6_valid", ov1, 0);
        check("t6_grant", g1, 0);
        rst = 0; out_ready = 1; in_valid = 4'b1111; in_last = '1;
        cyc();
        check("t6_first", g1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = 4'($urandom);
            in_data   = N*W'($urandom);
            for (int k = 0; k < N; k++) in_last[k] = ($urandom_range(3) != 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
